// File: rtl/pipelined_floating_point_multiplier.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready handshake.
// S1 classifies operands and multiplies significands, S2 normalises and
// range-checks, S3 rounds, packs and drives the registered output.
// Subnormal inputs are flushed to zero. Optional sticky exception flags are
// built when FP_MUL_STICKY_FLAGS_EN is defined.
module pipelined_floating_point_multiplier #(
  parameter int unsigned EXPONENT_WIDTH   = 8,
  parameter int unsigned MANTISSA_WIDTH   = 23,
  parameter int unsigned ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic                                   flags_clear,
  output logic                                   sticky_underflow,
  output logic                                   sticky_overflow,
  output logic                                   sticky_invalid
`endif
);

  localparam int unsigned EW   = EXPONENT_WIDTH;
  localparam int unsigned MW   = MANTISSA_WIDTH;
  localparam int unsigned W    = EW + MW + 1;
  localparam int unsigned PW   = 2 * (MW + 1);
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned BIAS = (1 << (EW - 1)) - 1;

  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [MW-1:0] QNAN_MAN = ((EW == 4) && (MW == 3)) ? {MW{1'b1}}
                                                                 : {1'b1, {(MW-1){1'b0}}};
  localparam logic [W-1:0]  QNAN     = {1'b1, EXP_ONES, QNAN_MAN};

  // Handshake: the whole pipe freezes while a result waits at the output.
  logic stall_c;
  assign stall_c  = out_valid && !out_ready;
  assign in_ready = !stall_c;

  // Operand fields and classification.
  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic          a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign {a_sign, a_exp, a_man} = a;
  assign {b_sign, b_exp, b_man} = b;
  assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
  assign a_snan = a_nan && !a_man[MW-1];
  assign b_snan = b_nan && !b_man[MW-1];
  assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);

  // Stage registers.
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_special_q, s1_special_d;
  logic [W-1:0]         s1_spec_val_q, s1_spec_val_d;
  logic                 s1_invalid_q, s1_invalid_d;
  logic [PW-1:0]        s1_prod_q, s1_prod_d;
  logic signed [XW-1:0] s1_exp_q, s1_exp_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_special_q, s2_special_d;
  logic [W-1:0]         s2_spec_val_q, s2_spec_val_d;
  logic                 s2_invalid_q, s2_invalid_d;
  logic                 s2_uf_q, s2_uf_d;
  logic                 s2_of_q, s2_of_d;
  logic [EW-1:0]        s2_exp_q, s2_exp_d;
  logic [MW-1:0]        s2_man_q, s2_man_d;
  logic                 s2_guard_q, s2_guard_d;
  logic                 s2_sticky_q, s2_sticky_d;

  logic                 s3_valid_q, s3_valid_d;
  logic [W-1:0]         out_q, out_d;
  logic                 uf_q, uf_d;
  logic                 of_q, of_d;
  logic                 inv_q, inv_d;

  // S1: special-case resolution, significand product, biased exponent sum.
  always_comb begin
    s1_valid_d    = in_valid;
    s1_sign_d     = a_sign ^ b_sign;
    s1_special_d  = 1'b0;
    s1_spec_val_d = '0;
    s1_invalid_d  = 1'b0;
    s1_prod_d     = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
    s1_exp_d      = XW'(a_exp) + XW'(b_exp) - XW'(BIAS);
    if (a_nan || b_nan) begin
      s1_special_d  = 1'b1;
      s1_spec_val_d = QNAN;
      s1_invalid_d  = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      s1_special_d  = 1'b1;
      s1_spec_val_d = QNAN;
      s1_invalid_d  = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_special_d  = 1'b1;
      s1_spec_val_d = {s1_sign_d, EXP_ONES, MW'(0)};
    end else if (a_zero || b_zero) begin
      s1_special_d  = 1'b1;
      s1_spec_val_d = {s1_sign_d, (W-1)'(0)};
    end
  end

  // S2: normalise to a leading one, extract guard/sticky, detect range.
  logic                 prod_hi;
  logic [PW-2:0]        frac;
  logic signed [XW-1:0] exp_n;

  always_comb begin
    prod_hi       = s1_prod_q[PW-1];
    frac          = prod_hi ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
    exp_n         = s1_exp_q + XW'(prod_hi);
    s2_valid_d    = s1_valid_q;
    s2_sign_d     = s1_sign_q;
    s2_special_d  = s1_special_q;
    s2_spec_val_d = s1_spec_val_q;
    s2_invalid_d  = s1_invalid_q;
    s2_man_d      = frac[PW-2 -: MW];
    s2_guard_d    = frac[MW];
    s2_sticky_d   = |frac[MW-1:0];
    s2_exp_d      = exp_n[EW-1:0];
    s2_uf_d       = exp_n < $signed(XW'(1));
    s2_of_d       = exp_n >= $signed({2'b00, EXP_ONES});
  end

  // S3: round (ties to even), handle carry into exponent, pack result.
  logic          round_up;
  logic [MW:0]   man_r;
  logic [EW:0]   exp_r;

  always_comb begin
    round_up   = (ROUND_TO_NEAREST != 0) && s2_guard_q && (s2_sticky_q || s2_man_q[0]);
    man_r      = {1'b0, s2_man_q} + (MW+1)'(round_up);
    exp_r      = {1'b0, s2_exp_q} + (EW+1)'(man_r[MW]);
    s3_valid_d = s2_valid_q;
    out_d      = {s2_sign_q, exp_r[EW-1:0], man_r[MW-1:0]};
    uf_d       = 1'b0;
    of_d       = 1'b0;
    inv_d      = 1'b0;
    if (s2_special_q) begin
      out_d = s2_spec_val_q;
      inv_d = s2_invalid_q;
    end else if (s2_uf_q) begin
      out_d = {s2_sign_q, (W-1)'(0)};
      uf_d  = 1'b1;
    end else if (s2_of_q || (exp_r >= {1'b0, EXP_ONES})) begin
      out_d = {s2_sign_q, EXP_ONES, MW'(0)};
      of_d  = 1'b1;
    end
  end

  // Pipeline registers: cleared on reset, frozen during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_special_q  <= 1'b0;
      s1_spec_val_q <= '0;
      s1_invalid_q  <= 1'b0;
      s1_prod_q     <= '0;
      s1_exp_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_special_q  <= 1'b0;
      s2_spec_val_q <= '0;
      s2_invalid_q  <= 1'b0;
      s2_uf_q       <= 1'b0;
      s2_of_q       <= 1'b0;
      s2_exp_q      <= '0;
      s2_man_q      <= '0;
      s2_guard_q    <= 1'b0;
      s2_sticky_q   <= 1'b0;
      s3_valid_q    <= 1'b0;
      out_q         <= '0;
      uf_q          <= 1'b0;
      of_q          <= 1'b0;
      inv_q         <= 1'b0;
    end else if (!stall_c) begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_special_q  <= s1_special_d;
      s1_spec_val_q <= s1_spec_val_d;
      s1_invalid_q  <= s1_invalid_d;
      s1_prod_q     <= s1_prod_d;
      s1_exp_q      <= s1_exp_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_special_q  <= s2_special_d;
      s2_spec_val_q <= s2_spec_val_d;
      s2_invalid_q  <= s2_invalid_d;
      s2_uf_q       <= s2_uf_d;
      s2_of_q       <= s2_of_d;
      s2_exp_q      <= s2_exp_d;
      s2_man_q      <= s2_man_d;
      s2_guard_q    <= s2_guard_d;
      s2_sticky_q   <= s2_sticky_d;
      s3_valid_q    <= s3_valid_d;
      out_q         <= out_d;
      uf_q          <= uf_d;
      of_q          <= of_d;
      inv_q         <= inv_d;
    end
  end

  assign out_valid              = s3_valid_q;
  assign out                    = out_q;
  assign underflow_flag         = uf_q;
  assign overflow_flag          = of_q;
  assign invalid_operation_flag = inv_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic out_xfer_c;
  logic st_uf_q, st_uf_d, st_of_q, st_of_d, st_inv_q, st_inv_d;

  assign out_xfer_c = out_valid && out_ready;

  // Sticky next state: clear first, then OR in so a same-cycle set wins.
  always_comb begin
    st_uf_d  = (flags_clear ? 1'b0 : st_uf_q)  | (out_xfer_c && uf_q);
    st_of_d  = (flags_clear ? 1'b0 : st_of_q)  | (out_xfer_c && of_q);
    st_inv_d = (flags_clear ? 1'b0 : st_inv_q) | (out_xfer_c && inv_q);
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_uf_q  <= 1'b0;
      st_of_q  <= 1'b0;
      st_inv_q <= 1'b0;
    end else begin
      st_uf_q  <= st_uf_d;
      st_of_q  <= st_of_d;
      st_inv_q <= st_inv_d;
    end
  end

  assign sticky_underflow = st_uf_q;
  assign sticky_overflow  = st_of_q;
  assign sticky_invalid   = st_inv_q;
`endif

endmodule

// File: tb/tb_pipelined_floating_point_multiplier.sv
// Self-checking bench for pipelined_floating_point_multiplier (binary32 build).
// Scoreboard compares every output transfer against an integer reference model.
module tb_pipelined_floating_point_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic        uf, of, inv;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic        flags_clear;
  logic        st_uf, st_of, st_inv;
`endif

  always #5 clk = ~clk;

  pipelined_floating_point_multiplier dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .a                      (a),
    .b                      (b),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out                    (out),
    .underflow_flag         (uf),
    .overflow_flag          (of),
    .invalid_operation_flag (inv)
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    .flags_clear            (flags_clear),
    .sticky_underflow       (st_uf),
    .sticky_overflow        (st_of),
    .sticky_invalid         (st_inv)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {invalid, overflow, underflow, result}.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic s;
    bit nx, ny, snx, sny, ix, iy, zx, zy;
    longint unsigned p, m, rem, half;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    s   = x[31] ^ y[31];
    nx  = (ex == 255) && (x[22:0] != 0);
    ny  = (ey == 255) && (y[22:0] != 0);
    snx = nx && !x[22];
    sny = ny && !y[22];
    ix  = (ex == 255) && !nx;
    iy  = (ey == 255) && !ny;
    zx  = (ex == 0);
    zy  = (ey == 0);
    if (nx || ny) return {snx | sny, 2'b00, 32'hFFC00000};
    if ((ix && zy) || (zx && iy)) return {3'b100, 32'hFFC00000};
    if (ix || iy) return {3'b000, s, 8'hFF, 23'h0};
    if (zx || zy) return {3'b000, s, 31'h0};
    p  = ((64'd1 << 23) | 64'(x[22:0])) * ((64'd1 << 23) | 64'(y[22:0]));
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    if (e < 1)    return {3'b001, s, 31'h0};
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && m[0])) m++;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    return {3'b000, s, 8'(e), m[22:0]};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        gold_en;
    logic [34:0] gold;
  } op_t;

  op_t         ops[$];
  logic [34:0] exp_q[$];
  logic        cur_gold_en;
  logic [34:0] cur_gold;
  int          xfer_cnt  = 0;
  int          seen_valid = 0;

  // Scoreboard: samples both handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) seen_valid++;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", {inv, of, uf, out}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", {inv, of, uf, out}, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_gold_en ? cur_gold : ref_mul(a, b));
    end
  end

  task automatic add_op(input logic [31:0] x, input logic [31:0] y);
    ops.push_back('{x, y, 1'b0, 35'h0});
  endtask

  task automatic add_gold(input logic [31:0] x, input logic [31:0] y, input logic [34:0] g);
    ops.push_back('{x, y, 1'b1, g});
  endtask

  // Streams queued operands back to back; starts and ends just after a posedge.
  task automatic run_ops();
    op_t o;
    int  k;
    bit  acc;
    while (ops.size() > 0) begin
      o           = ops.pop_front();
      a           = o.a;
      b           = o.b;
      cur_gold_en = o.gold_en;
      cur_gold    = o.gold;
      in_valid    = 1'b1;
      k   = 0;
      acc = 1'b0;
      while (!acc && k < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        k++;
      end
      if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
    end
    in_valid    = 1'b0;
    cur_gold_en = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_normal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = int'($urandom_range(0, 9));
    m   = 23'($urandom);
    case (sel)
      0:       e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) m = 23'h0;
      end
      2:       e = 8'($urandom_range(190, 254));
      3:       e = 8'($urandom_range(1, 64));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic test_latency();
    add_gold(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    run_ops();
    @(negedge clk); check_eq("lat_c1", 64'(out_valid), 64'd0);
    @(negedge clk); check_eq("lat_c2", 64'(out_valid), 64'd0);
    @(negedge clk); check_eq("lat_c3", 64'(out_valid), 64'd1);
    check_eq("lat_out", {inv, of, uf, out}, {3'b000, 32'h40400000});
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_specials();
    add_gold(32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
    add_gold(32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
    add_gold(32'h00800000, 32'h00800000, {3'b001, 32'h00000000});
    add_gold(32'h00000000, 32'hFF800000, {3'b100, 32'hFFC00000});
    add_gold(32'h7F800001, 32'h3F800000, {3'b100, 32'hFFC00000});
    add_gold(32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000});
    add_gold(32'h80000000, 32'h40000000, {3'b000, 32'h80000000});
    add_gold(32'h7FC00000, 32'h3F800000, {3'b000, 32'hFFC00000});
    add_gold(32'h00400000, 32'h40000000, {3'b000, 32'h00000000});
    add_gold(32'hC0000000, 32'h40400000, {3'b000, 32'hC0C00000});
    run_ops();
    wait_drain();
  endtask

  task automatic test_stall();
    int          xfer0, k;
    logic [34:0] held;
    xfer0 = xfer_cnt;
    repeat (4) add_op(rnd_normal(), rnd_normal());
    fork
      run_ops();
      begin
        k = 0;
        while (!out_valid && k < 50) begin
          @(posedge clk);
          #1;
          k++;
        end
        check_eq("stall_start", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held      = {inv, of, uf, out};
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_in_ready", 64'(in_ready), 64'd0);
          check_eq("stall_hold", {inv, of, uf, out}, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("stall_count", 64'(xfer_cnt - xfer0), 64'd4);
  endtask

  task automatic test_reset();
    int seen0;
    out_ready = 1'b1;
    repeat (3) add_op(rnd_normal(), rnd_normal());
    run_ops();
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out", 64'(out), 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    seen0 = seen_valid;
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_stale", 64'(seen_valid - seen0), 64'd0);
  endtask

  task automatic test_random();
    bit busy;
    busy = 1'b1;
    repeat (300) add_op(rnd_fp(), rnd_fp());
    fork
      begin
        run_ops();
        busy = 1'b0;
      end
      begin
        while (busy) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_drain();
  endtask

`ifdef FP_MUL_STICKY_FLAGS_EN
  task automatic pulse_clear();
    flags_clear = 1'b1;
    @(posedge clk);
    #1;
    flags_clear = 1'b0;
  endtask

  task automatic test_sticky();
    pulse_clear();
    check_eq("sticky_clr0", 64'(st_of), 64'd0);
    add_gold(32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
    add_gold(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    add_gold(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    run_ops();
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check_eq("sticky_of_held", 64'(st_of), 64'd1);
    check_eq("sticky_uf_quiet", 64'(st_uf), 64'd0);
    check_eq("sticky_inv_quiet", 64'(st_inv), 64'd0);
    pulse_clear();
    check_eq("sticky_of_cleared", 64'(st_of), 64'd0);
  endtask
`endif

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = 32'h0;
    b           = 32'h0;
    out_ready   = 1'b1;
    cur_gold_en = 1'b0;
    cur_gold    = 35'h0;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flags_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_out", {inv, of, uf, out}, 64'd0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_latency();
    test_specials();
    test_stall();
    test_reset();
    test_random();
`ifdef FP_MUL_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_floating_point_multiplier.md
PIPELINED_FLOATING_POINT_MULTIPLIER -- requirements
Module: pipelined_floating_point_multiplier

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored mantissa width.
REQ-003 SHALL have parameter ROUND_TO_NEAREST, default 1, 0 = truncate, 1 = round-to-nearest-even.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operands a/b are valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts operands this cycle.
REQ-008 SHALL have ports a and b, input, W = EXPONENT_WIDTH+MANTISSA_WIDTH+1 each, packed {sign, exponent, mantissa}.
REQ-009 SHALL have port out_valid, output, 1, out and flags are valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 SHALL have port out, output, W, product.
REQ-012 SHALL have ports underflow_flag, overflow_flag and invalid_operation_flag, output, 1 each, per-result exception flags qualified by out_valid.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 classifies operands and forms the (MANTISSA_WIDTH+1)x(MANTISSA_WIDTH+1) product and the signed (EXPONENT_WIDTH+2)-bit exponent sum minus bias; S2 normalises and detects range; S3 rounds, packs and registers the output.
REQ-014 SHALL produce a transfer on in_valid&&in_ready and a transfer on out_valid&&out_ready; with no stall, the result appears exactly 3 cycles after acceptance.
REQ-015 SHALL compute stall = out_valid && !out_ready and drive in_ready = !stall; while stall is high, all stage registers hold their contents.
REQ-016 SHALL not collapse bubbles; with out_ready held high, in_valid held high, and no stalls, the block sustains one result per cycle.
REQ-017 SHALL keep out and the flags stable while out_valid=1 and out_ready=0.
REQ-018 SHALL treat subnormal inputs (exponent 0) as signed zero, i.e. flush-to-zero.
REQ-019 SHALL handle NaN operands as follows: any NaN operand gives quiet NaN {1, all-ones exponent, 1, zeros}; when EXPONENT_WIDTH=4 and MANTISSA_WIDTH=3, the mantissa of that quiet NaN is all ones.
REQ-020 SHALL raise invalid_operation_flag for any signaling-NaN operand or for 0 x inf, and SHALL return quiet NaN for 0 x inf.
REQ-021 SHALL return correctly signed infinity for inf x nonzero finite, with no flag; zero x finite SHALL return signed zero with no flag.
REQ-022 SHALL compute the result sign as a_sign XOR b_sign for all non-NaN results.
REQ-023 SHALL flush to signed zero and raise underflow_flag when the normalised exponent is below 1.
REQ-024 SHALL return signed infinity and raise overflow_flag when the normalised exponent is at or above all-ones, or when rounding carries the exponent to all-ones.
REQ-025 SHALL round with guard and sticky bits taken from the lower MANTISSA_WIDTH+1 product bits; a ties-to-even mantissa carry SHALL increment the exponent.

Reset
REQ-026 SHALL clear all stage-valid bits, out_valid and all flags while rst=1; out SHALL reset to 0.
REQ-027 SHALL immediately discard in-flight operations on reset asserted mid-operation; in_ready SHALL be 1 after reset.

Configuration
REQ-028 SHALL, when FP_MUL_STICKY_FLAGS_EN is defined, add input flags_clear (1 bit) and outputs sticky_underflow, sticky_overflow and sticky_invalid; each sticky output ORs in its per-result flag on every output transfer, clears on flags_clear, and set wins when both occur in the same cycle; each resets to 0.
REQ-029 SHALL, when FP_MUL_STICKY_FLAGS_EN is undefined, omit those ports and the sticky logic entirely.

Verification
REQ-030 SHALL cover: a=0x3FC00000, b=0x40000000, out_ready=1 -> out=0x40400000 exactly 3 cycles later, with no flags.
REQ-031 SHALL cover: 4 back-to-back operands with out_ready low for 5 cycles starting at the first result -> in_ready=0 during the stall, and all 4 results delivered in order, none lost or duplicated.
REQ-032 SHALL cover: a=0x7F000000, b=0x7F000000 -> out=0x7F800000 with overflow_flag=1; a=0x00800000, b=0x00800000 -> out=0x00000000 with underflow_flag=1.
REQ-033 SHALL cover: a=0x00000000, b=0xFF800000 -> out=0xFFC00000 with invalid_operation_flag=1; a=0x7F800001 (sNaN), b=0x3F800000 -> out=0xFFC00000 with invalid_operation_flag=1.
REQ-034 SHALL cover: rst asserted with 3 operations in flight -> out_valid=0 in the same cycle, and no stale result appears after rst deasserts.
REQ-035 SHALL cover, with FP_MUL_STICKY_FLAGS_EN defined: an overflow result, then normal results -> sticky_overflow stays 1 until flags_clear is pulsed.
